// File: rtl/jk_excitation_counter.sv
// Mod-MODULUS up/down counter built from JK flip-flops; next state is applied
// through per-bit (J,K) excitation derived from the desired target value.
module jk_excitation_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] J_out,
  output logic [WIDTH-1:0] K_out,
  output logic             TC
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_illegal;
  logic             w_load_ok;

  // Illegal states (Q >= MODULUS) wrap like the terminal value in either direction.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] q,
                                               input logic up, input logic at_max,
                                               input logic at_zero, input logic illegal);
    if (up) f_step = (at_max || illegal) ? '0 : q + 1'b1;
    else    f_step = (at_zero || illegal) ? LP_MAX : q - 1'b1;
  endfunction

  assign w_at_max  = (r_q == LP_MAX);
  assign w_at_zero = (r_q == '0);
  assign w_illegal = ({1'b0, r_q} >= LP_MOD);
  assign w_load_ok = ({1'b0, D} < LP_MOD);

  always_comb begin
    w_next = r_q;
    if (!Reset)     w_next = '0;
    else if (Load)  w_next = w_load_ok ? D : '0;
    else if (En)    w_next = f_step(r_q, Up, w_at_max, w_at_zero, w_illegal);
  end

  // Excitation table with don't-cares resolved to 0; J=K=1 cannot occur.
  assign w_j = ~r_q & w_next;
  assign w_k = r_q & ~w_next;

  always_ff @(posedge Clk) begin
    if (!Reset) r_q <= '0;
    else        r_q <= (w_j & ~r_q) | (~w_k & r_q);
  end

  assign Q     = r_q;
  assign Qbar  = ~r_q;
  assign J_out = w_j;
  assign K_out = w_k;
  assign TC    = Reset & ~Load & En & ((Up & w_at_max) | (~Up & w_at_zero));

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Scoreboard bench for jk_excitation_counter (WIDTH=4, MODULUS=10).
module tb_jk_excitation_counter;

  logic       Clk = 1'b0;
  logic       Reset, En, Up, Load;
  logic [3:0] D;
  logic [3:0] Q, Qbar, J_out, K_out;
  logic       TC;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_q;
  logic [3:0] sb_q[$];

  jk_excitation_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .Qbar(Qbar), .J_out(J_out), .K_out(K_out), .TC(TC)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] q, input logic rst,
                                            input logic ld, input logic en,
                                            input logic up, input logic [3:0] d);
    if (!rst)     return 4'd0;
    else if (ld)  return (d >= 4'd10) ? 4'd0 : d;
    else if (en) begin
      if (up) return (q >= 4'd9) ? 4'd0 : q + 4'd1;
      else    return (q == 4'd0 || q >= 4'd10) ? 4'd9 : q - 4'd1;
    end
    return q;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic up, input logic [3:0] d);
    logic [3:0] n, ej, ek, jp, kp, qp, e, eqb;
    logic       etc;
    Reset = rst; Load = ld; En = en; Up = up; D = d;
    #1;
    n   = model_next(m_q, rst, ld, en, up, d);
    ej  = ~m_q & n;
    ek  = m_q & ~n;
    etc = rst & ~ld & en & ((up & (m_q == 4'd9)) | (~up & (m_q == 4'd0)));
    check_val("J_out", J_out, ej);
    check_val("K_out", K_out, ek);
    check_val("TC", TC, etc);
    jp = J_out; kp = K_out; qp = Q;
    sb_q.push_back(n);
    @(posedge Clk);
    #1;
    check_val("JK_eq", Q, (jp & ~qp) | (~kp & qp));
    check_val("JK_excl", jp & kp, 32'd0);
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e   = sb_q.pop_front();
      eqb = ~e;
      check_val("Q", Q, e);
      check_val("Qbar", Qbar, eqb);
      m_q = e;
    end
  endtask

  initial begin
    Reset = 1'b0; En = 1'b0; Up = 1'b1; Load = 1'b0; D = 4'd0;
    @(posedge Clk);
    #1;
    m_q = 4'd0;
    check_val("rst_Q", Q, 32'd0);
    check_val("rst_Qbar", Qbar, 32'hF);
    check_val("rst_TC", TC, 32'd0);

    // Reset from Q=7: K_out must equal Q before the edge
    step(1, 1, 0, 1, 4'd7);
    Reset = 1'b0; Load = 1'b0; En = 1'b1; #1;
    check_val("rst_K7", K_out, 32'h7);
    step(0, 0, 1, 1, 4'd0);

    // Up count through the wrap
    for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 4'd0);

    // Down from 0
    step(0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'd0);

    // Load priority and out-of-range load
    step(1, 1, 1, 1, 4'd5);
    step(1, 1, 1, 0, 4'd12);
    step(1, 1, 0, 0, 4'd15);
    step(1, 1, 1, 1, 4'd3);
    step(0, 1, 1, 1, 4'd8);

    // Hold at 6
    step(1, 1, 0, 1, 4'd6);
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom_range(0, 1), 4'd0);

    // Random traffic
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
